uart_framed: RTL and testbench

UART_FRAMED -- requirements
Module: uart_framed

---
 rtl/uart_framed.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_framed.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_framed.sv
// rtl/uart_framed.sv - framed UART with independent TX/RX engines.
// Define UART_FRAMED_RX_FIFO_EN to buffer RX words in a FIFO_DEPTH FIFO instead of one holding register.
module uart_framed #(
  parameter int CLOCKFRQ   = 240000000,
  parameter int BAUDRATE   = 3500000,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 tx_busy,
  output logic                 rx_busy
);
  localparam int DIV_RAW = CLOCKFRQ / (BAUDRATE * OVERSAMPLE);
  localparam int CLK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t tx_state, tx_state_n;
  logic [DW-1:0] tx_div;
  logic [TW-1:0] tx_tcnt;
  logic [BW-1:0] tx_bcnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic tx_par, tx_line_n, rst_done, tx_tick, tx_bit_end;

  // tx_ready stays low for the first cycle out of reset.
  assign tx_ready   = rst_done && (tx_state == TX_IDLE);
  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_tick    = (tx_div == DW'(CLK_DIV - 1));
  assign tx_bit_end = tx_tick && (tx_tcnt == TW'(OVERSAMPLE - 1));

  always_comb begin
    tx_state_n = tx_state;
    tx_line_n  = tx;
    case (tx_state)
      TX_IDLE: if (tx_valid && tx_ready) begin
        tx_state_n = TX_START;
        tx_line_n  = 1'b0;
      end
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        tx_line_n  = tx_shift[0];
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bcnt == BW'(DATA_BITS - 1)) begin
          tx_state_n = (PARITY != 0) ? TX_PAR : TX_STOP;
          tx_line_n  = (PARITY != 0) ? tx_par : 1'b1;
        end else begin
          tx_line_n = tx_shift[1];
        end
      end
      TX_PAR: if (tx_bit_end) begin
        tx_state_n = TX_STOP;
        tx_line_n  = 1'b1;
      end
      TX_STOP: if (tx_bit_end && tx_bcnt == BW'(STOP_BITS - 1)) tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      rst_done <= 1'b0;
      tx_div   <= '0;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx       <= tx_line_n;
      rst_done <= 1'b1;
      if (tx_valid && tx_ready) begin
        tx_shift <= tx_data;
        tx_par   <= ^tx_data ^ ODD_PAR;
        tx_div   <= '0;
        tx_tcnt  <= '0;
        tx_bcnt  <= '0;
      end else if (tx_state != TX_IDLE) begin
        tx_div <= tx_tick ? '0 : tx_div + 1'b1;
        if (tx_tick) tx_tcnt <= (tx_tcnt == TW'(OVERSAMPLE - 1)) ? '0 : tx_tcnt + 1'b1;
        if (tx_bit_end) begin
          tx_bcnt <= (tx_state_n != tx_state) ? '0 : tx_bcnt + 1'b1;
          if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
        end
      end
    end
  end

  rx_state_t rx_state, rx_state_n;
  logic rx_meta, rx_sync, rx_tick, rx_samp, rx_par_bad, rx_push;
  logic [DW-1:0] rx_div;
  logic [TW-1:0] rx_tcnt, rx_limit;
  logic [BW-1:0] rx_bcnt;
  logic [DATA_BITS-1:0] rx_shift;

  // Start bit is confirmed at mid-bit; every later sample is a full bit after the previous one.
  assign rx_limit = (rx_state == RX_START) ? TW'(OVERSAMPLE / 2 - 1) : TW'(OVERSAMPLE - 1);
  assign rx_tick  = (rx_div == DW'(CLK_DIV - 1));
  assign rx_samp  = rx_tick && (rx_tcnt == rx_limit);
  assign rx_busy  = (rx_state != RX_IDLE);
  assign rx_push       = (rx_state == RX_STOP) && rx_samp && rx_sync && !rx_par_bad;
  assign rx_frame_err  = (rx_state == RX_STOP) && rx_samp && !rx_sync;
  assign rx_parity_err = (rx_state == RX_STOP) && rx_samp && rx_sync && rx_par_bad;

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:      if (!rx_sync) rx_state_n = RX_START;
      RX_START:     if (rx_samp) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_samp && rx_bcnt == BW'(DATA_BITS - 1))
                      rx_state_n = (PARITY != 0) ? RX_PAR : RX_STOP;
      RX_PAR:       if (rx_samp) rx_state_n = RX_STOP;
      RX_STOP:      if (rx_samp) rx_state_n = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_sync) rx_state_n = RX_IDLE;
      default:      rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_div     <= '0;
      rx_tcnt    <= '0;
      rx_bcnt    <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_n;
      if (rx_state == RX_IDLE) begin
        rx_div     <= '0;
        rx_tcnt    <= '0;
        rx_bcnt    <= '0;
        rx_par_bad <= 1'b0;
      end else begin
        rx_div <= rx_tick ? '0 : rx_div + 1'b1;
        if (rx_tick) rx_tcnt <= rx_samp ? '0 : rx_tcnt + 1'b1;
        if (rx_samp && rx_state == RX_DATA) begin
          rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
          rx_bcnt  <= (rx_state_n != rx_state) ? '0 : rx_bcnt + 1'b1;
        end
        if (rx_samp && rx_state == RX_PAR) rx_par_bad <= ((^rx_shift) ^ rx_sync) != ODD_PAR;
      end
    end
  end

  logic do_pop, do_push;
  assign do_pop = rx_valid && rx_ready;

`ifdef UART_FRAMED_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [AW:0] count, remain;

  assign do_push = rx_push && ((count != (AW+1)'(FIFO_DEPTH)) || do_pop);
  assign rd_next = rd_ptr + AW'(do_pop);
  assign remain  = count - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_shift;
  end

  // rx_data is pre-loaded with the next head so it stays a plain register output.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_next;
      count      <= remain + (AW+1)'(do_push);
      rx_valid   <= (remain != '0) || do_push;
      rx_overrun <= rx_push && !do_push;
      if (remain != '0) rx_data <= mem[rd_next];
      else if (do_push) rx_data <= rx_shift;
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  assign do_push = rx_push && (!rx_valid || do_pop);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_push && !do_push;
      if (do_push) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shift;
      end else if (do_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_uart_framed.sv
// tb/tb_uart_framed.sv - self-checking bench for uart_framed (8 data bits, even parity, 2 stop bits).
module tb_uart_framed;
  logic clk = 1'b0, nRst = 1'b0, rx = 1'b1, tx_valid = 1'b0, rx_ready = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx, tx_ready, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, tx_busy, rx_busy;
  logic [7:0] rx_data;

  uart_framed #(
    .CLOCKFRQ(48000000), .BAUDRATE(3000000), .OVERSAMPLE(8), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .nRst(nRst), .rx(rx), .tx(tx), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun),
    .tx_busy(tx_busy), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

`ifdef UART_FRAMED_RX_FIFO_EN
  localparam int STORE = 4;
`else
  localparam int STORE = 1;
`endif

  int tests = 0, fails = 0, cyc = 0;
  int got_n = 0, rd_idx = 0, ferr_n = 0, perr_n = 0, ovr_n = 0;
  int start_cyc = 0, last_lat = 0;
  logic low_busy = 1'b0;
  logic [7:0] got [64];
  int got_cyc [64];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nRst && rx_valid && rx_ready && got_n < 64) begin
      got[got_n]     <= rx_data;
      got_cyc[got_n] <= cyc;
      got_n          <= got_n + 1;
    end
    if (rx_frame_err)  ferr_n <= ferr_n + 1;
    if (rx_parity_err) perr_n <= perr_n + 1;
    if (rx_overrun)    ovr_n  <= ovr_n + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [11:0] b;
    b[0]    = 1'b0;
    b[8:1]  = d;
    b[9]    = (^d) ^ bad_par;
    b[10]   = !bad_stop;
    b[11]   = 1'b1;
    return b;
  endfunction

  task automatic send_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int extra_low);
    logic [11:0] b;
    b = frame_bits(d, bad_par, bad_stop);
    @(negedge clk);
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    if (extra_low > 0) begin
      repeat (extra_low / 2) @(negedge clk);
      low_busy = rx_busy;
      repeat (extra_low - extra_low / 2) @(negedge clk);
    end
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic sb_drain(input string name);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      int w;
      e = exp_q.pop_front();
      w = 0;
      while (got_n <= rd_idx && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (got_n <= rd_idx) check({name, "_timeout"}, got_n, rd_idx + 1);
      else begin
        check(name, got[rd_idx], e);
        last_lat = got_cyc[rd_idx] - start_cyc;
        rd_idx++;
      end
    end
    repeat (4) @(negedge clk);
    check({name, "_extra"}, got_n, rd_idx);
  endtask

  task automatic wait_tx_ready(input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!tx_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    check(name, tx_ready, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit bad_par;
    bit bad_stop;
    bit word;
    int ferr;
    int perr;
  } rx_vec_t;

  rx_vec_t vecs [6];

  initial begin
    logic [11:0] fb;
    int bad [12];
    int f0, p0, o0, g0;

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b1, 0, 0};

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", {tx_busy, rx_busy}, 0);
    check("rst_err", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    nRst = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      f0 = ferr_n;
      p0 = perr_n;
      if (vecs[v].word) exp_q.push_back(vecs[v].data);
      send_rx(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop, 0);
      sb_drain($sformatf("rx_vec%0d_data", v));
      if (v == 0) check("rx_latency_in_stop_bit", (last_lat >= 166 && last_lat <= 176), 1);
      check($sformatf("rx_vec%0d_frame_err", v), ferr_n - f0, vecs[v].ferr);
      check($sformatf("rx_vec%0d_parity_err", v), perr_n - p0, vecs[v].perr);
    end

    f0 = ferr_n; p0 = perr_n; g0 = got_n;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_idle", rx_busy, 0);
    check("glitch_no_word", got_n, g0);
    check("glitch_no_err", (ferr_n - f0) + (perr_n - p0), 0);

    f0 = ferr_n; g0 = got_n;
    send_rx(8'h66, 1'b0, 1'b1, 48);
    check("ferr_pulse", ferr_n - f0, 1);
    check("ferr_wait_high_busy", low_busy, 1);
    check("ferr_no_word", got_n, g0);
    exp_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b0, 1'b0, 0);
    sb_drain("ferr_recover_data");

    @(posedge clk);
    #1 rx_ready = 1'b0;
    o0 = ovr_n;
    for (int i = 0; i <= STORE; i++) begin
      if (i == STORE) check("ovr_none_before_last", ovr_n - o0, 0);
      if (i < STORE) exp_q.push_back(8'h10 + 8'(i * 17));
      send_rx(8'h10 + 8'(i * 17), 1'b0, 1'b0, 0);
    end
    repeat (8) @(negedge clk);
    check("ovr_pulse", ovr_n - o0, 1);
    check("ovr_valid_held", rx_valid, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    sb_drain("ovr_data");

    fb = frame_bits(8'hA5, 1'b0, 1'b0);
    for (int b = 0; b < 12; b++) bad[b] = 0;
    wait_tx_ready("tx_ready_idle");
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_data = 8'hFF;
        check("tx_ready_drop", tx_ready, 0);
        check("tx_busy", tx_busy, 1);
      end
      if (k == 50) tx_valid = 1'b0;
      if (tx !== fb[k / 16]) bad[k / 16]++;
      if (k == 191) check("tx_ready_last_stop", tx_ready, 0);
    end
    for (int b = 0; b < 12; b++) check($sformatf("tx_bit%0d_samples_wrong", b), bad[b], 0);
    @(negedge clk);
    check("tx_ready_after_frame", tx_ready, 1);
    check("tx_idle_high", tx, 1);

    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (72) @(negedge clk);
    check("tx_bit3_low", tx, 0);
    nRst = 1'b0;
    @(negedge clk);
    check("rstmid_tx_high", tx, 1);
    check("rstmid_tx_ready", tx_ready, 0);
    check("rstmid_tx_busy", tx_busy, 0);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    check("rstmid_tx_ready_rise", tx_ready, 1);
    check("rstmid_tx_still_high", tx, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
